repeat_pattern_checker: RTL and testbench
=========================================

REPEAT_PATTERN_CHECKER -- requirements
Module: repeat_pattern_checker

Interface
REQ-001 SHALL have parameter NDIG, default 11: number of BCD digits in the ID word.
REQ-002 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: an ID is offered.
REQ-006 SHALL have port in_ready  output  1: the block can accept an ID.
REQ-007 SHALL have port in_bcd  input  4*NDIG: ID with digit 0 (least significant) in bits [3:0].
REQ-008 SHALL have port in_mode  input  1: 0 = exactly-twice repeat, 1 = repeated two or more times.
REQ-009 SHALL have port out_valid  output  1: a result is presented.
REQ-010 SHALL have port out_ready  input  1: the consumer takes the result.
REQ-011 SHALL have port out_match  output  1: the ID is a repeated pattern.
REQ-012 SHALL have port out_len  output  clog2(NDIG+1): significant digit count of the ID.
REQ-013 SHALL have port out_period  output  clog2(NDIG+1): period of the match; 0 when there is no match.
REQ-014 SHALL have port match_count  output  CNT_W: number of matching results consumed.
REQ-015 SHALL have port clr_count  input  1: synchronous clear of match_count.

Function
REQ-016 SHALL implement the states IDLE, LEN, SCAN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 SHALL accept an ID on an edge where in_valid && in_ready; it SHALL register in_bcd and in_mode and move to LEN.
REQ-018 In LEN, SHALL compute len as (index of the highest nonzero digit) + 1; len SHALL be 0 for an all-zero ID.
REQ-019 SHALL NOT range-check digit values; codes above 9 SHALL be compared as-is.
REQ-020 From LEN in mode 0: if len is even and at least 2, SHALL go to SCAN with p = len/2; otherwise SHALL go to DONE with no match.
REQ-021 From LEN in mode 1: if len is at least 2, SHALL go to SCAN with p = 1; otherwise SHALL go to DONE with no match.
REQ-022 Each SCAN cycle SHALL test one period p, and p SHALL match iff len % p == 0 and digit[i] == digit[i+p] for every i < len-p.
REQ-023 On a match in SCAN, SHALL go to DONE with out_match=1 and out_period=p.
REQ-024 In mode 1 without a match, SHALL increment p; when p+1 > len/2 it SHALL go to DONE with no match.
REQ-025 In mode 0, the single SCAN test SHALL be the only test before DONE.
REQ-026 Mode 1 SHALL report the smallest matching period.
REQ-027 Latency SHALL be as follows: with the accept edge as cycle 0, LEN is cycle 1, SCAN cycles follow, and out_valid SHALL rise on the cycle after the last SCAN cycle (or after LEN if there are no SCAN cycles).
REQ-028 out_match, out_len and out_period SHALL be held stable while out_valid=1 and out_ready=0.
REQ-029 On a DONE edge with out_ready=1, SHALL go to IDLE; the block SHALL NOT accept a new ID on that same edge.
REQ-030 match_count SHALL increment by 1 on a DONE handshake with out_match=1, and SHALL saturate at all-ones.
REQ-031 clr_count SHALL zero match_count on the next edge, and SHALL win over a simultaneous increment.
REQ-032 clr_count SHALL NOT affect the FSM or any other output.

Reset
REQ-033 When rst=1 on an edge, SHALL force IDLE, in_ready=1, out_valid=0, out_match=0, out_len=0, out_period=0 and match_count=0.
REQ-034 Reset SHALL take priority over every other input.
REQ-035 A reset during LEN, SCAN or DONE SHALL drop the in-flight ID without producing a result or a count change.

Verification
REQ-036 Mode 1, ID 222222 -> match, len=6, period=1, out_valid at cycle 3.
REQ-037 ID 565656 -> mode 0: no match, len=6, period=0. Mode 1: match, period=2, out_valid at cycle 4.
REQ-038 ID 123123123 -> mode 0: no match, out_valid at cycle 2. Mode 1: match, period=3.
REQ-039 IDs 0 and 7, both modes -> no match, len=0 and 1 respectively, out_valid at cycle 2.
REQ-040 Mode 0, ID 1212, out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout; match_count goes 0 to 1 at the handshake. Also: clr_count on the handshake edge -> match_count=0.
REQ-041 Reset asserted during SCAN of 1111111111 in mode 1 -> IDLE next cycle, no out_valid, match_count unchanged at 0. Also: with CNT_W=2 and 5 matches consumed -> match_count=3.

Source files
------------

// File: rtl/repeat_pattern_checker_if.sv
// rtl/repeat_pattern_checker_if.sv - ID request / result handshake bundle for repeat_pattern_checker
interface repeat_pattern_checker_if #(
    parameter int NDIG  = 11,
    parameter int LEN_W = $clog2(NDIG + 1)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIG-1:0]      in_bcd;
    logic                   in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_match;
    logic [LEN_W-1:0]       out_len;
    logic [LEN_W-1:0]       out_period;

    // Producer of IDs and consumer of results
    modport master (
        output in_valid, in_bcd, in_mode, out_ready,
        input  in_ready, out_valid, out_match, out_len, out_period
    );

    // The checker itself
    modport slave (
        input  in_valid, in_bcd, in_mode, out_ready,
        output in_ready, out_valid, out_match, out_len, out_period
    );
endinterface

// File: rtl/repeat_pattern_checker.sv
// rtl/repeat_pattern_checker.sv - detects BCD IDs built from a repeated digit pattern
module repeat_pattern_checker #(
    parameter int NDIG  = 11,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    repeat_pattern_checker_if.slave bus,
    output logic [CNT_W-1:0]     match_count,
    input  logic                 clr_count
);
    localparam int LEN_W = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [4*NDIG-1:0]   bcd_q;
    logic                mode_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    p_q;
    logic                match_q;
    logic [LEN_W-1:0]    period_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    count_q;

    logic [LEN_W-1:0]    len_d;
    logic [4*NDIG-1:0]   shifted_d;
    logic                hit_d;

    // Significant length: position of the highest nonzero digit plus one
    always_comb begin
        len_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                len_d = LEN_W'(i + 1);
            end
        end
    end

    // Period test: the ID compared against itself shifted down by p digits
    always_comb begin
        shifted_d = bcd_q >> {p_q, 2'b00};
        hit_d     = 1'b0;
        if (p_q != '0 && (len_q % p_q) == '0) begin
            hit_d = 1'b1;
            for (int i = 0; i < NDIG; i++) begin
                if ((i < int'(len_q) - int'(p_q)) && (bcd_q[4*i +: 4] != shifted_d[4*i +: 4])) begin
                    hit_d = 1'b0;
                end
            end
        end
    end

    // Control FSM: accept, measure length, scan periods, present result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            p_q         <= '0;
            match_q     <= 1'b0;
            period_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        bcd_q      <= bus.in_bcd;
                        mode_q     <= bus.in_mode;
                        match_q    <= 1'b0;
                        period_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= LEN;
                    end
                end
                LEN: begin
                    len_q <= len_d;
                    if (!mode_q && !len_d[0] && len_d >= LEN_W'(2)) begin
                        p_q     <= len_d >> 1;
                        state_q <= SCAN;
                    end else if (mode_q && len_d >= LEN_W'(2)) begin
                        p_q     <= LEN_W'(1);
                        state_q <= SCAN;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                SCAN: begin
                    if (hit_d) begin
                        match_q     <= 1'b1;
                        period_q    <= p_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (!mode_q || (p_q + LEN_W'(1)) > (len_q >> 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        p_q <= p_q + LEN_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of consumed matches; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            count_q <= '0;
        end else if (state_q == DONE && bus.out_ready && match_q && count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_match  = match_q;
    assign bus.out_len    = len_q;
    assign bus.out_period = period_q;
    assign match_count    = count_q;
endmodule

// File: tb/tb_repeat_pattern_checker.sv
// tb/tb_repeat_pattern_checker.sv - self-checking bench for repeat_pattern_checker
module tb_repeat_pattern_checker;
    localparam int NDIG = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          exp_a = 0;
    int          exp_b = 0;

    always #5 clk = ~clk;

    repeat_pattern_checker_if #(.NDIG(NDIG)) aif ();
    repeat_pattern_checker_if #(.NDIG(NDIG)) bif ();

    assign bif.in_valid  = aif.in_valid;
    assign bif.in_bcd    = aif.in_bcd;
    assign bif.in_mode   = aif.in_mode;
    assign bif.out_ready = aif.out_ready;

    repeat_pattern_checker #(.NDIG(NDIG), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(aif.slave), .match_count(cnt_a), .clr_count(clr)
    );
    repeat_pattern_checker #(.NDIG(NDIG), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bif.slave), .match_count(cnt_b), .clr_count(clr)
    );

    function automatic logic periodic(input logic [43:0] bcd, input int len, input int p);
        logic [3:0] a, b;
        if (len % p != 0) return 1'b0;
        for (int i = 0; i < len; i++) begin
            a = bcd[4*i +: 4];
            b = bcd[4*(i % p) +: 4];
            if (a != b) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model(input logic [43:0] bcd, input logic mode,
                                  output logic m, output int len, output int per, output int cyc);
        len = 0;
        for (int i = 0; i < NDIG; i++) if (bcd[4*i +: 4] != 4'd0) len = i + 1;
        m = 1'b0; per = 0; cyc = 2;
        if (!mode) begin
            if (len >= 2 && len % 2 == 0) begin
                cyc = 3;
                if (periodic(bcd, len, len / 2)) begin m = 1'b1; per = len / 2; end
            end
        end else if (len >= 2) begin
            cyc = 2 + len / 2;
            for (int p = 1; p <= len / 2; p++) begin
                if (periodic(bcd, len, p)) begin m = 1'b1; per = p; cyc = 2 + p; break; end
            end
        end
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a = 0; exp_b = 0;
    endtask

    // Offers one ID from IDLE, waits for the result, holds, then consumes it
    task automatic run_id(input logic [43:0] bcd, input logic mode, input int hold, input logic clr_hs,
                          output logic gm, output int gl, output int gp, output int gc);
        logic em; int el, ep, ec;
        model(bcd, mode, em, el, ep, ec);
        aif.in_valid = 1'b1; aif.in_bcd = bcd; aif.in_mode = mode;
        @(posedge clk); #1;
        aif.in_valid = 1'b0;
        gc = 1;
        while (!aif.out_valid && gc < 40) begin @(posedge clk); #1; gc++; end
        gm = aif.out_match; gl = int'(aif.out_len); gp = int'(aif.out_period);
        tests_run++;
        if (!aif.out_valid || gc !== ec) begin
            tests_failed++;
            $display("FAIL latency id=%h mode=%0d got=%0d valid=%0b need=%0d", bcd, mode, gc, aif.out_valid, ec);
        end
        tests_run++;
        if (gm !== em || gl !== el || gp !== ep) begin
            tests_failed++;
            $display("FAIL result id=%h mode=%0d got m=%0b len=%0d per=%0d need m=%0b len=%0d per=%0d",
                     bcd, mode, gm, gl, gp, em, el, ep);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            tests_run++;
            if (aif.out_valid !== 1'b1 || aif.in_ready !== 1'b0 || aif.out_match !== em ||
                int'(aif.out_len) !== el || int'(aif.out_period) !== ep) begin
                tests_failed++;
                $display("FAIL hold id=%h cyc=%0d got v=%0b r=%0b m=%0b len=%0d per=%0d need v=1 r=0 m=%0b len=%0d per=%0d",
                         bcd, h, aif.out_valid, aif.in_ready, aif.out_match, aif.out_len, aif.out_period, em, el, ep);
            end
        end
        aif.out_ready = 1'b1; clr = clr_hs;
        @(posedge clk); #1;
        aif.out_ready = 1'b0; clr = 1'b0;
        if (clr_hs) begin exp_a = 0; exp_b = 0; end
        else if (em) begin
            if (exp_a < 65535) exp_a++;
            if (exp_b < 3) exp_b++;
        end
        tests_run++;
        if (aif.out_valid !== 1'b0 || aif.in_ready !== 1'b1 || int'(cnt_a) !== exp_a || int'(cnt_b) !== exp_b) begin
            tests_failed++;
            $display("FAIL handshake id=%h got v=%0b r=%0b cnt=%0d/%0d need v=0 r=1 cnt=%0d/%0d",
                     bcd, aif.out_valid, aif.in_ready, cnt_a, cnt_b, exp_a, exp_b);
        end
    endtask

    task automatic test_reset();
        aif.in_valid = 1'b1; aif.in_bcd = 44'h1212; aif.in_mode = 1'b0; aif.out_ready = 1'b0;
        apply_reset();
        aif.in_valid = 1'b0;
        tests_run++;
        if (aif.in_ready !== 1'b1 || aif.out_valid !== 1'b0 || aif.out_match !== 1'b0 ||
            aif.out_len !== 4'd0 || aif.out_period !== 4'd0 || cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset got r=%0b v=%0b m=%0b len=%0d per=%0d cnt=%0d/%0d need r=1 v=0 m=0 len=0 per=0 cnt=0/0",
                     aif.in_ready, aif.out_valid, aif.out_match, aif.out_len, aif.out_period, cnt_a, cnt_b);
        end
    endtask

    typedef struct {
        logic [43:0] id; logic mode; logic m; int len; int per; int cyc;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        logic gm; int gl, gp, gc;
        v[0] = '{44'h222222,    1'b1, 1'b1, 6, 1, 3};
        v[1] = '{44'h565656,    1'b0, 1'b0, 6, 0, 3};
        v[2] = '{44'h565656,    1'b1, 1'b1, 6, 2, 4};
        v[3] = '{44'h123123123, 1'b0, 1'b0, 9, 0, 2};
        v[4] = '{44'h123123123, 1'b1, 1'b1, 9, 3, 5};
        v[5] = '{44'h0,         1'b0, 1'b0, 0, 0, 2};
        v[6] = '{44'h0,         1'b1, 1'b0, 0, 0, 2};
        v[7] = '{44'h7,         1'b0, 1'b0, 1, 0, 2};
        v[8] = '{44'h7,         1'b1, 1'b0, 1, 0, 2};
        v[9] = '{44'hABAB,      1'b0, 1'b1, 4, 2, 3};
        for (int k = 0; k < 10; k++) begin
            run_id(v[k].id, v[k].mode, 0, 1'b0, gm, gl, gp, gc);
            tests_run++;
            if (gm !== v[k].m || gl !== v[k].len || gp !== v[k].per || gc !== v[k].cyc) begin
                tests_failed++;
                $display("FAIL directed id=%h mode=%0d got m=%0b len=%0d per=%0d cyc=%0d need m=%0b len=%0d per=%0d cyc=%0d",
                         v[k].id, v[k].mode, gm, gl, gp, gc, v[k].m, v[k].len, v[k].per, v[k].cyc);
            end
        end
    endtask

    task automatic test_hold_and_clear();
        logic gm; int gl, gp, gc;
        apply_reset();
        run_id(44'h1212, 1'b0, 5, 1'b0, gm, gl, gp, gc);
        tests_run++;
        if (cnt_a !== 16'd1) begin
            tests_failed++;
            $display("FAIL count_after_hold got=%0d need=1", cnt_a);
        end
        run_id(44'h1212, 1'b0, 2, 1'b1, gm, gl, gp, gc);
        tests_run++;
        if (cnt_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL clear_on_handshake got=%0d need=0", cnt_a);
        end
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        aif.in_valid = 1'b1; aif.in_bcd = 44'h1111111111; aif.in_mode = 1'b1;
        @(posedge clk); #1;
        aif.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (aif.in_ready !== 1'b1 || aif.out_valid !== 1'b0 || cnt_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_scan got r=%0b v=%0b cnt=%0d need r=1 v=0 cnt=0", aif.in_ready, aif.out_valid, cnt_a);
        end
        aif.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (aif.out_valid !== 1'b0 || aif.in_ready !== 1'b1 || cnt_a !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_mid_scan_after cyc=%0d got v=%0b r=%0b cnt=%0d need v=0 r=1 cnt=0",
                         k, aif.out_valid, aif.in_ready, cnt_a);
            end
        end
        aif.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic gm; int gl, gp, gc;
        apply_reset();
        aif.in_valid = 1'b1; aif.in_bcd = 44'h1212; aif.in_mode = 1'b0;
        @(posedge clk); #1;
        aif.in_valid = 1'b0;
        gc = 1;
        while (!aif.out_valid && gc < 40) begin @(posedge clk); #1; gc++; end
        tests_run++;
        if (!aif.out_valid || gc !== 3) begin
            tests_failed++;
            $display("FAIL b2b_first_latency got=%0d valid=%0b need=3", gc, aif.out_valid);
        end
        aif.in_valid = 1'b1; aif.in_bcd = 44'h565656; aif.in_mode = 1'b1; aif.out_ready = 1'b1;
        @(posedge clk); #1;
        aif.out_ready = 1'b0;
        exp_a++; exp_b++;
        tests_run++;
        if (aif.in_ready !== 1'b1 || aif.out_valid !== 1'b0 || int'(cnt_a) !== exp_a) begin
            tests_failed++;
            $display("FAIL b2b_no_accept_on_handshake got r=%0b v=%0b cnt=%0d need r=1 v=0 cnt=%0d",
                     aif.in_ready, aif.out_valid, cnt_a, exp_a);
        end
        run_id(44'h565656, 1'b1, 0, 1'b0, gm, gl, gp, gc);
    endtask

    task automatic test_saturation();
        logic gm; int gl, gp, gc;
        apply_reset();
        for (int k = 0; k < 5; k++) run_id(44'h77, 1'b1, 0, 1'b0, gm, gl, gp, gc);
        tests_run++;
        if (cnt_b !== 2'd3 || cnt_a !== 16'd5) begin
            tests_failed++;
            $display("FAIL saturation got cnt2=%0d cnt16=%0d need cnt2=3 cnt16=5", cnt_b, cnt_a);
        end
    endtask

    task automatic test_random();
        logic gm; int gl, gp, gc;
        logic [43:0] id;
        logic [3:0]  d;
        int len, p;
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(0, NDIG);
            p   = (len == 0) ? 1 : $urandom_range(1, len);
            id  = '0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) != 0 && i >= p) d = id[4*(i % p) +: 4];
                else if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
                else d = 4'($urandom_range(0, 9));
                id[4*i +: 4] = d;
            end
            run_id(id, 1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                   gm, gl, gp, gc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aif.in_valid = 1'b0; aif.in_bcd = '0; aif.in_mode = 1'b0; aif.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold_and_clear();
        test_reset_mid_scan();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
